// File: rtl/uart_tx_fifo.sv
// UART transmitter with a write-side FIFO.
// A frame is a start bit, NB_DATA data bits sent LSB first, an optional parity bit and M_STOP stop bits.
module uart_tx_fifo #(
    parameter int NB_DATA    = 8,
    parameter int M_STOP     = 1,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int LOG2_DEPTH = 2
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_tick,
    input  logic [NB_DATA-1:0]   i_data,
    input  logic                 i_wr,
    input  logic [1:0]           i_parity_mode,
    output logic                 o_data,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [LOG2_DEPTH:0]  o_count,
    output logic                 o_busy,
    output logic                 o_tx_done,
    output logic                 o_overflow
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

    localparam int              TW        = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0]   TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [3:0]      DATA_LAST = 4'(NB_DATA - 1);
    localparam logic [3:0]      STOP_LAST = 4'(M_STOP - 1);

    // FIFO storage and pointers
    logic [NB_DATA-1:0]    mem_q [FIFO_DEPTH];
    logic [LOG2_DEPTH-1:0] wr_ptr_q, rd_ptr_q;
    logic [LOG2_DEPTH:0]   count_q, count_d;
    logic                  overflow_q;
    logic                  full_w, empty_w, push, pop;
    logic [NB_DATA-1:0]    head;

    // Serialiser state
    state_t              state_q, state_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic [3:0]          bit_q, bit_d;
    logic [NB_DATA-1:0]  shift_q, shift_d;
    logic                par_en_q, par_en_d;
    logic                par_bit_q, par_bit_d;
    logic                line_q, line_d;
    logic                done_q, done_d;
    logic                load, bit_end;

    assign full_w  = (count_q == (LOG2_DEPTH+1)'(FIFO_DEPTH));
    assign empty_w = (count_q == '0);
    assign push    = i_wr && !full_w;
    assign head    = mem_q[rd_ptr_q];
    assign bit_end = (tick_q == TICK_LAST);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (LOG2_DEPTH+1)'(1);
            2'b01:   count_d = count_q - (LOG2_DEPTH+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (push) mem_q[wr_ptr_q] <= i_data;
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + LOG2_DEPTH'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + LOG2_DEPTH'(1);
            count_q    <= count_d;
            overflow_q <= i_wr && full_w;
        end
    end

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        line_d    = line_q;
        done_d    = 1'b0;
        load      = 1'b0;
        pop       = 1'b0;
        if (i_tick) begin
            if (state_q == S_IDLE) begin
                load = !empty_w;
            end else if (!bit_end) begin
                tick_d = tick_q + TW'(1);
            end else begin
                tick_d = '0;
                case (state_q)
                    S_START: begin
                        line_d  = shift_q[0];
                        shift_d = shift_q >> 1;
                        bit_d   = '0;
                        state_d = S_DATA;
                    end
                    S_DATA: begin
                        if (bit_q == DATA_LAST) begin
                            bit_d = '0;
                            if (par_en_q) begin
                                line_d  = par_bit_q;
                                state_d = S_PARITY;
                            end else begin
                                line_d  = 1'b1;
                                state_d = S_STOP;
                            end
                        end else begin
                            line_d  = shift_q[0];
                            shift_d = shift_q >> 1;
                            bit_d   = bit_q + 4'd1;
                        end
                    end
                    S_PARITY: begin
                        line_d  = 1'b1;
                        bit_d   = '0;
                        state_d = S_STOP;
                    end
                    S_STOP: begin
                        if (bit_q == STOP_LAST) begin
                            done_d = 1'b1;
                            if (!empty_w) begin
                                load = 1'b1;
                            end else begin
                                line_d  = 1'b1;
                                state_d = S_IDLE;
                            end
                        end else begin
                            bit_d = bit_q + 4'd1;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end
        // Frame start: parity is fixed from the popped byte and the mode at pop time
        if (load) begin
            pop       = 1'b1;
            shift_d   = head;
            par_en_d  = (i_parity_mode == 2'b01) || (i_parity_mode == 2'b10);
            par_bit_d = (i_parity_mode == 2'b10) ? ~^head : ^head;
            tick_d    = '0;
            bit_d     = '0;
            line_d    = 1'b0;
            state_d   = S_START;
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            line_q    <= 1'b1;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            line_q    <= line_d;
            done_q    <= done_d;
        end
    end

    assign o_data     = line_q;
    assign o_full     = full_w;
    assign o_empty    = empty_w;
    assign o_count    = count_q;
    assign o_busy     = (state_q != S_IDLE);
    assign o_tx_done  = done_q;
    assign o_overflow = overflow_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: default 8N1 instance plus a 7-bit, 2-stop instance.
// Expected frames are hand-built as {stop.., parity, data, start} with bit 0 sent first.
module tb_uart_tx_fifo;
    localparam int OS = 16;

    logic       clk = 1'b0;
    logic       rst_n, tick, wr, wr2;
    logic [7:0] din;
    logic [6:0] din2;
    logic [1:0] mode, mode2;
    logic       o_data, o_full, o_empty, o_busy, o_tx_done, o_overflow;
    logic [2:0] o_count;
    logic       o_data2, o_full2, o_empty2, o_busy2, o_tx_done2, o_overflow2;
    logic [2:0] o_count2;

    int  vectors = 0;
    int  fails   = 0;
    int  ticks_seen = 0;
    bit  tick_en = 1'b0;
    bit  phase   = 1'b0;
    bit  ok;

    always #5 clk = ~clk;

    uart_tx_fifo u_dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_tick(tick), .i_data(din), .i_wr(wr),
        .i_parity_mode(mode), .o_data(o_data), .o_full(o_full), .o_empty(o_empty),
        .o_count(o_count), .o_busy(o_busy), .o_tx_done(o_tx_done), .o_overflow(o_overflow)
    );

    uart_tx_fifo #(.NB_DATA(7), .M_STOP(2)) u_dut2 (
        .i_clock(clk), .i_reset_n(rst_n), .i_tick(tick), .i_data(din2), .i_wr(wr2),
        .i_parity_mode(mode2), .o_data(o_data2), .o_full(o_full2), .o_empty(o_empty2),
        .o_count(o_count2), .o_busy(o_busy2), .o_tx_done(o_tx_done2), .o_overflow(o_overflow2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; ticks land on every other edge while enabled
    task automatic cyc();
        @(posedge clk);
        if (tick) ticks_seen++;
        #1;
        phase = ~phase;
        tick  = tick_en && phase;
    endtask

    task automatic wait_ticks(input int n);
        int target = ticks_seen + n;
        int guard  = 0;
        while (ticks_seen < target && guard < 10000) begin
            cyc();
            guard++;
        end
    endtask

    task automatic write1(input logic [7:0] d);
        din = d; wr = 1'b1;
        cyc();
        wr = 1'b0;
    endtask

    function automatic logic line_of(input bit d2);
        return d2 ? o_data2 : o_data;
    endfunction

    task automatic wait_start(input string tag, input bit d2);
        int guard = 0;
        while (line_of(d2) !== 1'b0 && guard < 2000) begin
            cyc();
            guard++;
        end
        chk({tag, "_start"}, {31'd0, line_of(d2)}, 32'd0);
    endtask

    task automatic check_frame(input string tag, input logic [15:0] exp, input int nbits, input bit d2);
        wait_start(tag, d2);
        for (int b = 0; b < nbits; b++) begin
            wait_ticks(OS/2);
            chk($sformatf("%s_bit%0d", tag, b), {31'd0, line_of(d2)}, {31'd0, exp[b]});
            if (d2) chk($sformatf("%s_busy%0d", tag, b), {31'd0, o_busy2}, 32'd1);
            wait_ticks(OS/2);
        end
        chk({tag, "_done"}, {31'd0, (d2 ? o_tx_done2 : o_tx_done)}, 32'd1);
    endtask

    initial begin
        rst_n = 1'b0; tick = 1'b0; wr = 1'b0; wr2 = 1'b0;
        din = '0; din2 = '0; mode = 2'b00; mode2 = 2'b00;
        cyc(); cyc();
        chk("rst_data",  {31'd0, o_data},    32'd1);
        chk("rst_empty", {31'd0, o_empty},   32'd1);
        chk("rst_full",  {31'd0, o_full},    32'd0);
        chk("rst_count", {29'd0, o_count},   32'd0);
        chk("rst_busy",  {31'd0, o_busy},    32'd0);
        chk("rst_done",  {31'd0, o_tx_done}, 32'd0);
        chk("rst_ovf",   {31'd0, o_overflow},32'd0);
        rst_n = 1'b1;
        cyc();

        // 0xA5, no parity
        tick_en = 1'b1;
        write1(8'hA5);
        check_frame("a5_none", 16'h034A, 10, 1'b0);
        cyc();
        chk("a5_done_clr", {31'd0, o_tx_done}, 32'd0);
        chk("a5_idle",     {31'd0, o_busy},    32'd0);
        chk("a5_line",     {31'd0, o_data},    32'd1);

        // 0x07 even then odd parity
        mode = 2'b01;
        write1(8'h07);
        check_frame("x07_even", 16'h060E, 11, 1'b0);
        mode = 2'b10;
        write1(8'h07);
        check_frame("x07_odd", 16'h040E, 11, 1'b0);

        // Back-to-back frames, no idle bit between them
        mode = 2'b00;
        write1(8'h11);
        write1(8'h22);
        check_frame("b2b_11", 16'h0222, 10, 1'b0);
        chk("b2b_gap", {31'd0, o_data}, 32'd0);
        check_frame("b2b_22", 16'h0244, 10, 1'b0);
        cyc();
        chk("b2b_idle", {31'd0, o_busy}, 32'd0);

        // Fill the FIFO with no ticks, then overflow
        tick_en = 1'b0;
        cyc(); cyc();
        write1(8'h01); chk("fill_c1", {29'd0, o_count}, 32'd1);
        write1(8'h02); chk("fill_c2", {29'd0, o_count}, 32'd2);
        chk("fill_nfull", {31'd0, o_full}, 32'd0);
        write1(8'h03); chk("fill_c3", {29'd0, o_count}, 32'd3);
        write1(8'h04); chk("fill_c4", {29'd0, o_count}, 32'd4);
        chk("fill_full", {31'd0, o_full}, 32'd1);
        chk("fill_noovf", {31'd0, o_overflow}, 32'd0);
        write1(8'h05); chk("fill_c5", {29'd0, o_count}, 32'd4);
        chk("fill_ovf", {31'd0, o_overflow}, 32'd1);
        cyc();
        chk("fill_ovf_clr", {31'd0, o_overflow}, 32'd0);
        chk("fill_hold_line", {31'd0, o_data}, 32'd1);
        tick_en = 1'b1;
        check_frame("fifo_01", 16'h0202, 10, 1'b0);
        check_frame("fifo_02", 16'h0204, 10, 1'b0);
        check_frame("fifo_03", 16'h0206, 10, 1'b0);
        check_frame("fifo_04", 16'h0208, 10, 1'b0);
        cyc();
        chk("fifo_empty", {31'd0, o_empty}, 32'd1);
        chk("fifo_idle",  {31'd0, o_busy},  32'd0);

        // 7 data bits, even parity, 2 stop bits: 11 bits
        mode2 = 2'b01;
        din2 = 7'h55; wr2 = 1'b1;
        cyc();
        wr2 = 1'b0;
        check_frame("d2_55", 16'h06AA, 11, 1'b1);
        cyc();
        chk("d2_idle", {31'd0, o_busy2}, 32'd0);

        // Reset in the middle of data bit 3
        mode = 2'b00;
        write1(8'hA5);
        write1(8'h3C);
        wait_start("rst_mid", 1'b0);
        wait_ticks(OS + 3*OS + OS/2);
        chk("mid_busy",  {31'd0, o_busy},  32'd1);
        chk("mid_count", {29'd0, o_count}, 32'd1);
        rst_n = 1'b0;
        cyc();
        chk("mid_rst_line",  {31'd0, o_data},    32'd1);
        chk("mid_rst_busy",  {31'd0, o_busy},    32'd0);
        chk("mid_rst_count", {29'd0, o_count},   32'd0);
        chk("mid_rst_done",  {31'd0, o_tx_done}, 32'd0);
        rst_n = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if (o_data !== 1'b1 || o_tx_done !== 1'b0 || o_busy !== 1'b0) ok = 1'b0;
        end
        chk("post_rst_quiet", {31'd0, ok}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
